// File: rtl/signal_sync_filt.sv
// signal_sync_filt
//   Multi-channel CDC synchroniser with a per-channel stability filter and
//   optional registered edge pulses.
//
//   Parameters:
//     Width     - number of independent channels
//     Depth     - synchroniser flop stages (2..8)
//     FilterLen - stable cycles before sigout follows (0 and 1 = bypass)
//     ResetVal  - reset level of the synchroniser stages and sigout
//   Ports:
//     clk     - single clock, rising edge
//     rst_n   - asynchronous, active-low reset
//     sig     - asynchronous input levels [Width]
//     sigout  - synchronised, filtered levels [Width]
//     rise    - one-cycle pulse on a 0->1 sigout update [Width]
//     fall    - one-cycle pulse on a 1->0 sigout update [Width]
//     changed - OR of all rise/fall bits, same cycle
//   Build option:
//     SIGNAL_SYNC_FILT_EDGE_EN - when defined, builds the rise/fall/changed
//     registers; otherwise those outputs are tied to 0.

// Per-channel stability filter: sigout_q follows s only after s has differed
// from it for max(FilterLen,1) consecutive cycles. upd flags the update event
// in the cycle before sigout_q takes the new level.
module signal_sync_filt_chan #(
    parameter int   FilterLen = 0,
    parameter logic RstVal    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic sigout_q,
    output logic upd
);
    logic sigout_d;

    generate
        if (FilterLen <= 1) begin : g_bypass
            // A single register: any difference is accepted on the next edge.
            always_comb begin
                sigout_d = s;
                upd      = (s != sigout_q);
            end
        end else begin : g_cnt
            localparam int            CW   = $clog2(FilterLen + 1);
            localparam logic [CW-1:0] TERM = CW'(FilterLen - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d    = cnt_q;
                sigout_d = sigout_q;
                upd      = 1'b0;
                if (s == sigout_q) begin
                    // Level returned (or never left): discard any partial run.
                    cnt_d = '0;
                end else if (cnt_q == TERM) begin
                    sigout_d = s;
                    upd      = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sigout_q <= RstVal;
        else        sigout_q <= sigout_d;
    end
endmodule

module signal_sync_filt #(
    parameter int               Width     = 1,
    parameter int               Depth     = 2,
    parameter int               FilterLen = 0,
    parameter logic [Width-1:0] ResetVal  = {Width{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] sig,
    output logic [Width-1:0] sigout,
    output logic [Width-1:0] rise,
    output logic [Width-1:0] fall,
    output logic             changed
);
    // Plain flop chain; stage 0 is the only flop that sees the async input.
    logic [Depth-1:0][Width-1:0] stage_q, stage_d;
    logic [Width-1:0]            s;
    logic [Width-1:0]            upd;

    always_comb begin
        stage_d = {stage_q[Depth-2:0], sig};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= {Depth{ResetVal}};
        else        stage_q <= stage_d;
    end

    assign s = stage_q[Depth-1];

    generate
        for (genvar i = 0; i < Width; i++) begin : g_ch
            signal_sync_filt_chan #(
                .FilterLen (FilterLen),
                .RstVal    (ResetVal[i])
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .s        (s[i]),
                .sigout_q (sigout[i]),
                .upd      (upd[i])
            );
        end
    endgenerate

`ifdef SIGNAL_SYNC_FILT_EDGE_EN
    logic [Width-1:0] rise_q, rise_d, fall_q, fall_d;
    logic             changed_q, changed_d;

    // Pulses are built from the next-state update events so they land in
    // the same cycle as the new sigout level.
    always_comb begin
        rise_d    = upd & s;
        fall_d    = upd & ~s;
        changed_d = |upd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;
`else
    logic unused_upd;
    assign unused_upd = ^upd;
    assign rise       = '0;
    assign fall       = '0;
    assign changed    = 1'b0;
`endif
endmodule

// File: tb/tb_signal_sync_filt.sv
// Bench for signal_sync_filt: several instances with different parameter
// sets share one clock. Table vectors, hand sequences for glitch / reset /
// maximum-length corners, and randomized stimulus against a window model.
module tb_signal_sync_filt;
`ifdef SIGNAL_SYNC_FILT_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_r;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // u0: 4 channels, bypass filter, ResetVal F
    logic [3:0] sig0, sigout0, rise0, fall0; logic changed0;
    signal_sync_filt #(.Width(4), .Depth(2), .FilterLen(0), .ResetVal(4'hF)) u0 (
        .clk(clk), .rst_n(rst_a), .sig(sig0), .sigout(sigout0),
        .rise(rise0), .fall(fall0), .changed(changed0));

    // u1: 4 channels, FilterLen 4 (randomized + glitch)
    localparam int L1 = 4, D1 = 2;
    logic [3:0] sig1, sigout1, rise1, fall1; logic changed1;
    signal_sync_filt #(.Width(4), .Depth(D1), .FilterLen(L1), .ResetVal(4'h0)) u1 (
        .clk(clk), .rst_n(rst_a), .sig(sig1), .sigout(sigout1),
        .rise(rise1), .fall(fall1), .changed(changed1));

    // u2: maximum parameters
    logic [0:0] sig2, sigout2, rise2, fall2; logic changed2;
    signal_sync_filt #(.Width(1), .Depth(8), .FilterLen(65535)) u2 (
        .clk(clk), .rst_n(rst_a), .sig(sig2), .sigout(sigout2),
        .rise(rise2), .fall(fall2), .changed(changed2));

    // u3: default parameters
    logic [0:0] sig3, sigout3, rise3, fall3; logic changed3;
    signal_sync_filt u3 (
        .clk(clk), .rst_n(rst_a), .sig(sig3), .sigout(sigout3),
        .rise(rise3), .fall(fall3), .changed(changed3));

    // u4: reset behaviour, FilterLen 8, own reset
    logic [1:0] sig4, sigout4, rise4, fall4; logic changed4;
    signal_sync_filt #(.Width(2), .Depth(2), .FilterLen(8), .ResetVal(2'b01)) u4 (
        .clk(clk), .rst_n(rst_r), .sig(sig4), .sigout(sigout4),
        .rise(rise4), .fall(fall4), .changed(changed4));

    // Reference for u1: sigout moves to v at edge n exactly when the L1 most
    // recent samples the filter has seen (sig captured at n-D1 .. n-D1-L1+1)
    // all equal v and v differs from the current output.
    logic [3:0] hist[$];
    logic [3:0] m_out = 4'h0, m_rise = 4'h0, m_fall = 4'h0;
    int         n, idx;
    logic       want, smp;
    bit         run;

    always @(posedge clk) begin
        if (rst_a) begin
            hist.push_back(sig1);
            n = hist.size() - 1;
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < 4; b++) begin
                want = ~m_out[b];
                run  = 1'b1;
                for (int k = 0; k < L1; k++) begin
                    idx = n - D1 - k;
                    smp = (idx < 0) ? 1'b0 : hist[idx][b];
                    if (smp != want) run = 1'b0;
                end
                if (run) begin
                    m_out[b]  = want;
                    m_rise[b] = want;
                    m_fall[b] = ~want;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_a) begin
            chk("u1_model_sigout", sigout1, m_out);
            chk("u1_model_rise", rise1, m_rise & {4{EDGE}});
            chk("u1_model_fall", fall1, m_fall & {4{EDGE}});
            chk("u1_model_changed", changed1, (|(m_rise | m_fall)) & EDGE);
        end
    end

    typedef struct {
        logic [3:0] sig;
        logic [3:0] sigout;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;
    vec_t vt[14];

    initial begin
        // Each row: sig applied before the edge, outputs expected after it.
        vt[0]  = '{4'hF, 4'hF, 4'h0, 4'h0};
        vt[1]  = '{4'hA, 4'hF, 4'h0, 4'h0};
        vt[2]  = '{4'hA, 4'hF, 4'h0, 4'h0};
        vt[3]  = '{4'hA, 4'hA, 4'h0, 4'h5};
        vt[4]  = '{4'hA, 4'hA, 4'h0, 4'h0};
        vt[5]  = '{4'hF, 4'hA, 4'h0, 4'h0};
        vt[6]  = '{4'hF, 4'hA, 4'h0, 4'h0};
        vt[7]  = '{4'hF, 4'hF, 4'h5, 4'h0};
        vt[8]  = '{4'hF, 4'hF, 4'h0, 4'h0};
        vt[9]  = '{4'h0, 4'hF, 4'h0, 4'h0};
        vt[10] = '{4'hF, 4'hF, 4'h0, 4'h0};
        vt[11] = '{4'hF, 4'h0, 4'h0, 4'hF};
        vt[12] = '{4'hF, 4'hF, 4'hF, 4'h0};
        vt[13] = '{4'hF, 4'hF, 4'h0, 4'h0};

        rst_a = 1'b0; rst_r = 1'b0;
        sig0 = 4'hF; sig1 = 4'h0; sig2 = 1'b0; sig3 = 1'b0; sig4 = 2'b01;
        repeat (3) @(negedge clk);
        chk("rst_u0_sigout", sigout0, 4'hF);
        chk("rst_u1_sigout", sigout1, 4'h0);
        chk("rst_u4_sigout", sigout4, 2'b01);
        chk("rst_u0_pulses", {rise0, fall0, 3'b0, changed0}, 0);
        rst_a = 1'b1; rst_r = 1'b1;

        fork
            begin : max_len
                @(negedge clk);
                sig2 = 1'b1;
                repeat (65542) @(posedge clk);
                @(negedge clk);
                chk("u2_max_before", sigout2, 1'b0);
                @(negedge clk);
                chk("u2_max_update", sigout2, 1'b1);
                chk("u2_max_rise", rise2, EDGE);
            end

            begin : main_seq
                // Table vectors on u0
                for (int i = 0; i < 14; i++) begin
                    sig0 = vt[i].sig;
                    @(negedge clk);
                    chk($sformatf("u0_vec%0d_sigout", i), sigout0, vt[i].sigout);
                    chk($sformatf("u0_vec%0d_rise", i), rise0, vt[i].rise & {4{EDGE}});
                    chk($sformatf("u0_vec%0d_fall", i), fall0, vt[i].fall & {4{EDGE}});
                    chk($sformatf("u0_vec%0d_changed", i), changed0,
                        (|(vt[i].rise | vt[i].fall)) & EDGE);
                end

                // Default parameters on u3: sigout at E+2, single rise
                sig3 = 1'b1;
                @(negedge clk);
                chk("u3_e0", sigout3, 1'b0);
                @(negedge clk);
                chk("u3_e1", sigout3, 1'b0);
                chk("u3_e1_fall", fall3, 1'b0);
                @(negedge clk);
                chk("u3_e2", sigout3, 1'b1);
                chk("u3_e2_rise", rise3, EDGE);
                chk("u3_e2_fall", fall3, 1'b0);
                @(negedge clk);
                chk("u3_e3_rise", rise3, 1'b0);
                chk("u3_e3_fall", fall3, 1'b0);

                // Glitch on u1 bit 0: three cycles high is rejected
                sig1 = 4'b0001;
                repeat (3) @(negedge clk);
                sig1 = 4'b0000;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("u1_glitch_sigout", sigout1, 4'h0);
                    chk("u1_glitch_rise", rise1, 4'h0);
                end
                // Stable high: accepted at E+1+4
                sig1 = 4'b0001;
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("u1_stable_e4", sigout1, 4'h0);
                @(negedge clk);
                chk("u1_stable_e5", sigout1, 4'h1);
                chk("u1_stable_rise", rise1, {3'b0, EDGE});
                @(negedge clk);
                chk("u1_stable_rise_off", rise1, 4'h0);

                // Randomized stimulus; the model checker does the comparing
                for (int c = 0; c < 600; c++) begin
                    for (int b = 0; b < 4; b++)
                        if ($urandom_range(7) == 0) sig1[b] = ~sig1[b];
                    @(negedge clk);
                end
            end

            begin : reset_seq
                repeat (3) @(negedge clk);
                sig4 = 2'b10;
                repeat (9) @(posedge clk);
                @(negedge clk);
                chk("u4_a_before", sigout4, 2'b01);
                @(negedge clk);
                chk("u4_a_update", sigout4, 2'b10);
                chk("u4_a_rise", rise4, 2'b10 & {2{EDGE}});
                chk("u4_a_fall", fall4, 2'b01 & {2{EDGE}});
                chk("u4_a_changed", changed4, EDGE);
                @(negedge clk);
                chk("u4_a_changed_off", changed4, 1'b0);

                // Count to 5 towards 01, then reset between edges
                sig4 = 2'b01;
                repeat (7) @(posedge clk);
                @(negedge clk);
                chk("u4_b_counting", sigout4, 2'b10);
                #2 rst_r = 1'b0;
                #1 chk("u4_b_async_rst", sigout4, 2'b01);
                chk("u4_b_rst_pulses", {rise4, fall4, changed4}, 0);
                repeat (2) @(negedge clk);
                rst_r = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    chk("u4_b_quiet_sigout", sigout4, 2'b01);
                    chk("u4_b_quiet_pulses", {rise4, fall4, changed4}, 0);
                end

                // Partial count discarded by reset; full length again after release
                sig4 = 2'b10;
                repeat (5) @(negedge clk);
                rst_r = 1'b0;
                @(negedge clk);
                rst_r = 1'b1;
                repeat (9) @(posedge clk);
                @(negedge clk);
                chk("u4_c_before", sigout4, 2'b01);
                @(negedge clk);
                chk("u4_c_update", sigout4, 2'b10);
                chk("u4_c_rise", rise4, 2'b10 & {2{EDGE}});
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
